// File: rtl/mips_ctrl_pkg.sv
// Operand-B selector codes and mode enumeration shared by the datapath and the control FSM.
// Immediate-mode codes are offsets above the last word-source index.
package mips_ctrl_pkg;

  localparam int unsigned SEL_SEXT    = 0;
  localparam int unsigned SEL_SEXT_SH = 1;
  localparam int unsigned SEL_ZEXT    = 2;

  typedef enum logic [2:0] {
    OPB_SRC,
    OPB_SEXT,
    OPB_SEXT_SH,
    OPB_ZEXT,
    OPB_ILLEGAL
  } opb_mode_e;

  function automatic opb_mode_e decode_sel(input int unsigned sel, input int unsigned num_src);
    if (sel < num_src)                        return OPB_SRC;
    else if (sel == num_src + SEL_SEXT)       return OPB_SEXT;
    else if (sel == num_src + SEL_SEXT_SH)    return OPB_SEXT_SH;
    else if (sel == num_src + SEL_ZEXT)       return OPB_ZEXT;
    else                                      return OPB_ILLEGAL;
  endfunction

endpackage

// File: rtl/operand_b_select_pipe_if.sv
// Request/response bundle for the operand-B selector; slave is the selector's view.
// Request side is valid/ready, response side is valid/ready plus a sticky error flag.
interface operand_b_select_pipe_if #(
  parameter int WIDTH     = 32,
  parameter int IMM_WIDTH = 16,
  parameter int NUM_SRC   = 2,
  parameter int SEL_W     = 3
) ();

  logic                     in_valid;
  logic                     in_ready;
  logic [SEL_W-1:0]         sel;
  logic [NUM_SRC*WIDTH-1:0] src_bus;
  logic [IMM_WIDTH-1:0]     imm;
  logic                     out_valid;
  logic                     out_ready;
  logic [WIDTH-1:0]         data_out;
  logic                     err_sel;

  modport master (
    output in_valid, sel, src_bus, imm, out_ready,
    input  in_ready, out_valid, data_out, err_sel
  );

  modport slave (
    input  in_valid, sel, src_bus, imm, out_ready,
    output in_ready, out_valid, data_out, err_sel
  );

endinterface

// File: rtl/skid_buffer.sv
// Two-entry valid/ready stage: main output register plus one skid register; 1-cycle latency.
// in_rdy is registered (!skid full); a held output stays stable; flush empties both entries.
module skid_buffer #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             flush,
  input  logic             in_vld,
  output logic             in_rdy,
  input  logic [WIDTH-1:0] in_dat,
  output logic             out_vld,
  input  logic             out_rdy,
  output logic [WIDTH-1:0] out_dat
);

  logic             main_vld_q, main_vld_d;
  logic [WIDTH-1:0] main_dat_q, main_dat_d;
  logic             skid_vld_q, skid_vld_d;
  logic [WIDTH-1:0] skid_dat_q, skid_dat_d;
  logic             push;
  logic             drain;

  assign in_rdy  = !skid_vld_q;
  assign out_vld = main_vld_q;
  assign out_dat = main_dat_q;
  assign push    = in_vld && in_rdy;
  assign drain   = main_vld_q && out_rdy;

  always_comb begin
    main_vld_d = main_vld_q;
    main_dat_d = main_dat_q;
    skid_vld_d = skid_vld_q;
    skid_dat_d = skid_dat_q;
    if (flush) begin
      main_vld_d = 1'b0;
      skid_vld_d = 1'b0;
    end else begin
      if (drain) begin
        main_vld_d = skid_vld_q;
        main_dat_d = skid_vld_q ? skid_dat_q : main_dat_q;
        skid_vld_d = 1'b0;
      end
      // push and a full skid never coincide, so the skid is free whenever main is held
      if (push && (!main_vld_q || drain)) begin
        main_vld_d = 1'b1;
        main_dat_d = in_dat;
      end else if (push) begin
        skid_vld_d = 1'b1;
        skid_dat_d = in_dat;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      main_vld_q <= 1'b0;
      main_dat_q <= '0;
      skid_vld_q <= 1'b0;
      skid_dat_q <= '0;
    end else begin
      main_vld_q <= main_vld_d;
      main_dat_q <= main_dat_d;
      skid_vld_q <= skid_vld_d;
      skid_dat_q <= skid_dat_d;
    end
  end

endmodule

// File: rtl/operand_b_select_pipe.sv
// Registered ALU operand-B selector (word sources or 16->32 immediate expansions); 1-cycle latency.
// Backpressure via a 2-entry skid stage; illegal selectors are consumed, dropped and flagged sticky.
module operand_b_select_pipe
  import mips_ctrl_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter int IMM_WIDTH = 16,
  parameter int NUM_SRC   = 2,
  parameter int SHIFT     = 2,
  parameter int SEL_W     = 3
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  flush,
  operand_b_select_pipe_if.slave bus
);

  logic [31:0]      sel_ext;
  logic [WIDTH-1:0] sext_w;
  logic [WIDTH-1:0] zext_w;
  logic [WIDTH-1:0] operand;
  logic             legal;
  opb_mode_e        mode;
  logic             in_rdy;
  logic             accept;
  logic             enq_vld;
  logic             out_vld;
  logic [WIDTH-1:0] out_dat;
  logic             err_sel_q, err_sel_d;

  assign sel_ext = {{(32-SEL_W){1'b0}}, bus.sel};
  assign sext_w  = {{(WIDTH-IMM_WIDTH){bus.imm[IMM_WIDTH-1]}}, bus.imm};
  assign zext_w  = {{(WIDTH-IMM_WIDTH){1'b0}}, bus.imm};
  assign mode    = decode_sel(sel_ext, NUM_SRC);

  always_comb begin
    operand = '0;
    legal   = 1'b1;
    case (mode)
      OPB_SRC: begin
        for (int i = 0; i < NUM_SRC; i++) begin
          if (sel_ext == 32'(i)) operand = bus.src_bus[i*WIDTH +: WIDTH];
        end
      end
      OPB_SEXT:    operand = sext_w;
      OPB_SEXT_SH: operand = sext_w << SHIFT;
      OPB_ZEXT:    operand = zext_w;
      default:     legal   = 1'b0;
    endcase
  end

  assign accept  = bus.in_valid && in_rdy;
  assign enq_vld = accept && legal && !flush;

  always_comb begin
    err_sel_d = err_sel_q | (accept & ~legal);
    if (flush) err_sel_d = 1'b0;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) err_sel_q <= 1'b0;
    else          err_sel_q <= err_sel_d;
  end

  skid_buffer #(.WIDTH(WIDTH)) u_skid (
    .clk     (clk),
    .reset_n (reset_n),
    .flush   (flush),
    .in_vld  (enq_vld),
    .in_rdy  (in_rdy),
    .in_dat  (operand),
    .out_vld (out_vld),
    .out_rdy (bus.out_ready),
    .out_dat (out_dat)
  );

  assign bus.in_ready  = in_rdy;
  assign bus.out_valid = out_vld;
  assign bus.data_out  = out_dat;
  assign bus.err_sel   = err_sel_q;

endmodule

// File: tb/tb_operand_b_select_pipe.sv
// Directed bench for operand_b_select_pipe with hand-computed expectations.
module tb_operand_b_select_pipe;
  import mips_ctrl_pkg::*;

  logic clk;
  logic reset_n;
  logic flush;
  int   n_checks;
  int   n_errors;

  logic [31:0] exp_modes [5] = '{32'h0000_00AA, 32'h0000_0004, 32'hFFFF_FFFC,
                                 32'hFFFF_FFF0, 32'h0000_FFFC};

  operand_b_select_pipe_if #(.WIDTH(32), .IMM_WIDTH(16), .NUM_SRC(2), .SEL_W(3)) bus ();

  operand_b_select_pipe #(
    .WIDTH(32), .IMM_WIDTH(16), .NUM_SRC(2), .SHIFT(2), .SEL_W(3)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .flush   (flush),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_checks      = 0;
    n_errors      = 0;
    reset_n       = 1'b0;
    flush         = 1'b0;
    bus.in_valid  = 1'b1;
    bus.sel       = 3'd0;
    bus.imm       = 16'h0000;
    bus.src_bus   = {32'h0000_0004, 32'h0000_00AA};
    bus.out_ready = 1'b1;

    // 1. reset state with a request pending, then first accept
    #12;
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_in_ready",  32'(bus.in_ready),  32'd1);
    check("rst_data_out",  bus.data_out,       32'd0);
    check("rst_err_sel",   32'(bus.err_sel),   32'd0);
    reset_n = 1'b1;
    tick();
    check("first_valid", 32'(bus.out_valid), 32'd1);
    check("first_data",  bus.data_out,       32'h0000_00AA);
    bus.in_valid = 1'b0;
    tick();
    check("first_drained", 32'(bus.out_valid), 32'd0);

    // 2. all legal modes back to back
    bus.imm = 16'hFFFC;
    for (int i = 0; i < 5; i++) begin
      bus.in_valid = 1'b1;
      bus.sel      = 3'(i);
      tick();
      check($sformatf("mode%0d_valid", i), 32'(bus.out_valid), 32'd1);
      check($sformatf("mode%0d_data", i),  bus.data_out,       exp_modes[i]);
    end
    bus.in_valid = 1'b0;
    tick();
    check("modes_idle", 32'(bus.out_valid), 32'd0);

    // 3. stall fills the skid
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.sel       = 3'd0;
    tick();
    check("stall_main_data",  bus.data_out,      32'h0000_00AA);
    check("stall_in_ready0",  32'(bus.in_ready), 32'd1);
    bus.sel = 3'd1;
    tick();
    check("stall_hold_data",  bus.data_out,      32'h0000_00AA);
    check("stall_in_ready1",  32'(bus.in_ready), 32'd0);
    bus.in_valid = 1'b0;
    tick();
    check("stall_hold_data2", bus.data_out,       32'h0000_00AA);
    check("stall_hold_valid", 32'(bus.out_valid), 32'd1);
    bus.out_ready = 1'b1;
    tick();
    check("unstall_data",     bus.data_out,       32'h0000_0004);
    check("unstall_valid",    32'(bus.out_valid), 32'd1);
    check("unstall_in_ready", 32'(bus.in_ready),  32'd1);
    tick();
    check("unstall_empty",    32'(bus.out_valid), 32'd0);

    // 4. illegal selector is consumed and flagged
    bus.in_valid = 1'b1;
    bus.sel      = 3'd5;
    tick();
    check("illegal_err",      32'(bus.err_sel),   32'd1);
    check("illegal_no_out",   32'(bus.out_valid), 32'd0);
    bus.sel = 3'd0;
    tick();
    check("after_illegal_valid", 32'(bus.out_valid), 32'd1);
    check("after_illegal_data",  bus.data_out,       32'h0000_00AA);
    bus.in_valid = 1'b0;
    tick();
    check("err_sticky",       32'(bus.err_sel),   32'd1);
    check("after_illegal_idle", 32'(bus.out_valid), 32'd0);

    // 5. flush with both entries full and a request presented
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.sel       = 3'd0;
    tick();
    bus.sel = 3'd1;
    tick();
    check("full_in_ready", 32'(bus.in_ready), 32'd0);
    flush   = 1'b1;
    bus.sel = 3'd2;
    bus.imm = 16'h0001;
    tick();
    flush        = 1'b0;
    bus.in_valid = 1'b0;
    check("flush_out_valid", 32'(bus.out_valid), 32'd0);
    check("flush_in_ready",  32'(bus.in_ready),  32'd1);
    check("flush_err_sel",   32'(bus.err_sel),   32'd0);
    bus.out_ready = 1'b1;
    tick();
    check("flush_stays_empty", 32'(bus.out_valid), 32'd0);

    // flush with in_ready high: the request must still be dropped
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.sel       = 3'd0;
    tick();
    check("flush2_main_full", 32'(bus.out_valid), 32'd1);
    flush   = 1'b1;
    bus.sel = 3'd2;
    tick();
    flush        = 1'b0;
    bus.in_valid = 1'b0;
    check("flush2_out_valid", 32'(bus.out_valid), 32'd0);
    tick();
    check("flush2_dropped",   32'(bus.out_valid), 32'd0);

    // 6. async reset between edges while stalled with error set
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    bus.sel       = 3'd5;
    tick();
    bus.out_ready = 1'b0;
    bus.sel       = 3'd0;
    tick();
    bus.sel = 3'd1;
    tick();
    bus.in_valid = 1'b0;
    check("pre_areset_in_ready", 32'(bus.in_ready), 32'd0);
    #2;
    reset_n = 1'b0;
    #1;
    check("areset_out_valid", 32'(bus.out_valid), 32'd0);
    check("areset_in_ready",  32'(bus.in_ready),  32'd1);
    check("areset_data_out",  bus.data_out,       32'd0);
    check("areset_err_sel",   32'(bus.err_sel),   32'd0);
    #3;
    reset_n = 1'b1;
    tick();
    check("post_areset_idle", 32'(bus.out_valid), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
